// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller behind MEM: req/gnt/rvalid handshake,
// pipeline stall, and aligned, sign/zero-extended registered load data.
// Optional build macro DMEM_TIMEOUT_EN adds a REQ+WAIT cycle limit with abort.
// Ports: clk_i, rst_ni; MEM side we_i/re_i/addr_i/store_strb_i/store_data_i/
//   byte_lane_i/access_size_i/unsigned_load_i; bus dbus_req_o/we_o/addr_o/
//   be_o/wdata_o, dbus_gnt_i/rvalid_i/rdata_i; stall_o, load_data_o,
//   load_valid_o, bus_err_o.
module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  store_strb_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  byte_lane_i,
  input  logic [1:0]  access_size_i,
  input  logic        unsigned_load_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        bus_err_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic       we_q;
  logic       uns_q;
  logic [1:0] lane_q;
  logic [1:0] size_q;
  logic       start;
  logic       done;
  logic       abort;
  logic [31:0] fmt;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Word address drops the lane bits; the lane comes in separately.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  assign start = (state_q == IDLE) && (we_i || re_i);
  assign done  = (state_q == WAIT) && dbus_rvalid_i;

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic          limit;

  assign limit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // A completing gnt/rvalid in the limit cycle takes priority.
  assign abort = limit &&
    (((state_q == REQ) && !dbus_gnt_i) ||
     ((state_q == WAIT) && !dbus_rvalid_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= abort;
      if (start)
        cnt_q <= '0;
      else if (state_q != IDLE)
        cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  assign abort     = 1'b0;
  assign bus_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (we_i || re_i) state_d = REQ;
      REQ: begin
        if (dbus_gnt_i)  state_d = WAIT;
        else if (abort)  state_d = IDLE;
      end
      WAIT: begin
        if (dbus_rvalid_i) state_d = IDLE;
        else if (abort)    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dbus_req_o = 1'b0;
    stall_o    = 1'b0;
    unique case (state_q)
      IDLE: stall_o = we_i || re_i;
      REQ: begin
        dbus_req_o = 1'b1;
        stall_o    = !abort;
      end
      WAIT: stall_o = !dbus_rvalid_i && !abort;
      default: stall_o = 1'b0;
    endcase
    dbus_we_o = dbus_req_o && we_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dbus_addr_o  <= '0;
      dbus_be_o    <= '0;
      dbus_wdata_o <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      lane_q       <= '0;
      size_q       <= '0;
    end else if (start) begin
      dbus_addr_o  <= {addr_i[31:2], 2'b00};
      dbus_be_o    <= we_i ? store_strb_i : 4'b1111;
      dbus_wdata_o <= store_data_i;
      we_q         <= we_i;
      uns_q        <= unsigned_load_i;
      lane_q       <= byte_lane_i;
      size_q       <= access_size_i;
    end
  end

  always_comb begin
    sel_b = dbus_rdata_i[7:0];
    unique case (lane_q)
      2'd0: sel_b = dbus_rdata_i[7:0];
      2'd1: sel_b = dbus_rdata_i[15:8];
      2'd2: sel_b = dbus_rdata_i[23:16];
      2'd3: sel_b = dbus_rdata_i[31:24];
      default: sel_b = dbus_rdata_i[7:0];
    endcase
    sel_h = lane_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    fmt = dbus_rdata_i;
    unique case (1'b1)
      (size_q == 2'b00):
        fmt = {{24{sel_b[7] & ~uns_q}}, sel_b};
      (size_q == 2'b01):
        fmt = {{16{sel_h[15] & ~uns_q}}, sel_h};
      default: fmt = dbus_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_data_o  <= '0;
      load_valid_o <= 1'b0;
    end else begin
      load_valid_o <= done && !we_q;
      if (done && !we_q)
        load_data_o <= fmt;
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: vector table of single transactions
// plus hand sequences for spurious rvalid, reset mid-WAIT and timeout.
module tb_dmem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re;
  logic [31:0] addr;
  logic [3:0]  strb;
  logic [31:0] sdata;
  logic [1:0]  lane, size;
  logic        uns;
  logic        req, bwe;
  logic [31:0] baddr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        stall;
  logic [31:0] ldata;
  logic        lvalid, berr;

  always #5 clk = ~clk;

  dmem_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .we_i(we), .re_i(re), .addr_i(addr),
    .store_strb_i(strb), .store_data_i(sdata),
    .byte_lane_i(lane), .access_size_i(size),
    .unsigned_load_i(uns),
    .dbus_req_o(req), .dbus_we_o(bwe),
    .dbus_addr_o(baddr), .dbus_be_o(be),
    .dbus_wdata_o(wdata),
    .dbus_gnt_i(gnt), .dbus_rvalid_i(rvalid),
    .dbus_rdata_i(rdata),
    .stall_o(stall), .load_data_o(ldata),
    .load_valid_o(lvalid), .bus_err_o(berr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [1:0]  size;
    logic        uns;
    int          gdly;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs[10];

  // Request is presented in the current cycle; the next request
  // follows in the load_valid cycle, so consecutive vectors are
  // back-to-back.
  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    we = v.we; re = !v.we;
    addr = v.addr; strb = v.strb; sdata = v.data;
    lane = v.addr[1:0]; size = v.size; uns = v.uns;
    #1;
    chk({t, " idle_stall"}, 32'(stall), 32'd1);
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    addr = 32'hFFFF_FFFF; strb = 4'h0; sdata = 32'h0;
    for (int i = 0; i <= v.gdly; i++) begin
      chk({t, " req"}, 32'(req), 32'd1);
      chk({t, " we"}, 32'(bwe), 32'(v.we));
      chk({t, " addr"}, baddr, v.exp_addr);
      chk({t, " be"}, 32'(be), 32'(v.exp_be));
      if (v.we) chk({t, " wdata"}, wdata, v.data);
      chk({t, " req_stall"}, 32'(stall), 32'd1);
      chk({t, " req_lvalid"}, 32'(lvalid), 32'd0);
      gnt = (i == v.gdly);
      @(posedge clk); #1;
    end
    gnt = 1'b0;
    #1;
    chk({t, " wait_req"}, 32'(req), 32'd0);
    chk({t, " wait_stall"}, 32'(stall), 32'd1);
    rvalid = 1'b1; rdata = v.rdata;
    #1;
    chk({t, " rv_stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = 32'h0;
    chk({t, " lvalid"}, 32'(lvalid), 32'(!v.we));
    chk({t, " berr"}, 32'(berr), 32'd0);
    if (!v.we) chk({t, " ldata"}, ldata, v.exp_load);
  endtask

  initial begin
    rst_n = 1'b0;
    we = 0; re = 0; addr = 0; strb = 0; sdata = 0;
    lane = 0; size = 0; uns = 0;
    gnt = 0; rvalid = 0; rdata = 0;

    //          we addr          strb   data          sz    u  g  rdata         exp_addr      be     load
    vecs[0] = '{1'b0, 32'h1003, 4'h0, 32'h0,        2'b00, 1'b0, 0, 32'h80FF_1234, 32'h1000, 4'hF, 32'hFFFF_FF80};
    vecs[1] = '{1'b1, 32'h2002, 4'hC, 32'hBEEF_0000, 2'b01, 1'b0, 3, 32'h0,        32'h2000, 4'hC, 32'h0};
    vecs[2] = '{1'b0, 32'h0012, 4'h0, 32'h0,        2'b01, 1'b1, 0, 32'h8001_0000, 32'h0010, 4'hF, 32'h0000_8001};
    vecs[3] = '{1'b0, 32'h0014, 4'h0, 32'h0,        2'b10, 1'b0, 0, 32'h1234_5678, 32'h0014, 4'hF, 32'h1234_5678};
    vecs[4] = '{1'b0, 32'h0022, 4'h0, 32'h0,        2'b01, 1'b0, 1, 32'h8001_0000, 32'h0020, 4'hF, 32'hFFFF_8001};
    vecs[5] = '{1'b0, 32'h0031, 4'h0, 32'h0,        2'b00, 1'b1, 0, 32'h0000_A500, 32'h0030, 4'hF, 32'h0000_00A5};
    vecs[6] = '{1'b0, 32'h0040, 4'h0, 32'h0,        2'b00, 1'b0, 2, 32'h0000_007F, 32'h0040, 4'hF, 32'h0000_007F};
    vecs[7] = '{1'b0, 32'h0050, 4'h0, 32'h0,        2'b11, 1'b0, 0, 32'hDEAD_BEEF, 32'h0050, 4'hF, 32'hDEAD_BEEF};
    vecs[8] = '{1'b1, 32'h0060, 4'hF, 32'hCAFE_BABE, 2'b10, 1'b0, 0, 32'h0,        32'h0060, 4'hF, 32'h0};
    vecs[9] = '{1'b1, 32'h0071, 4'h2, 32'h0000_5A00, 2'b00, 1'b0, 1, 32'h0,        32'h0070, 4'h2, 32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_we", 32'(bwe), 32'd0);
    chk("rst_addr", baddr, 32'd0);
    chk("rst_be", 32'(be), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_ldata", ldata, 32'd0);
    chk("rst_lvalid", 32'(lvalid), 32'd0);
    chk("rst_berr", 32'(berr), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_vec(i, vecs[i]);

    // Spurious rvalid while idle
    rvalid = 1'b1; rdata = 32'h5555_5555;
    #1;
    chk("spur_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("spur_lvalid", 32'(lvalid), 32'd0);
    chk("spur_req", 32'(req), 32'd0);
    chk("spur_ldata", ldata, 32'hDEAD_BEEF);

    // Reset in WAIT, then a late rvalid
    re = 1'b1; addr = 32'h84; lane = 2'd0; size = 2'b10; uns = 1'b0;
    @(posedge clk); #1;
    re = 1'b0; gnt = 1'b1;
    @(posedge clk); #1;
    gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_req", 32'(req), 32'd0);
    chk("mrst_addr", baddr, 32'd0);
    chk("mrst_be", 32'(be), 32'd0);
    chk("mrst_ldata", ldata, 32'd0);
    chk("mrst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
    #1;
    chk("late_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b0;
    chk("late_lvalid", 32'(lvalid), 32'd0);
    chk("late_ldata", ldata, 32'd0);
    chk("late_req", 32'(req), 32'd0);
    @(posedge clk); #1;
    chk("late_req2", 32'(req), 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // gnt never arrives: abort in the 8th REQ cycle
    re = 1'b1; addr = 32'h90; size = 2'b10;
    @(posedge clk); #1;
    re = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("to_req%0d", c), 32'(req), 32'd1);
      chk($sformatf("to_stall%0d", c), 32'(stall), 32'(c < 8));
      chk($sformatf("to_berr%0d", c), 32'(berr), 32'd0);
      @(posedge clk); #1;
    end
    chk("to_berr_pulse", 32'(berr), 32'd1);
    chk("to_req_drop", 32'(req), 32'd0);
    chk("to_lvalid", 32'(lvalid), 32'd0);
    chk("to_stall_idle", 32'(stall), 32'd0);
    @(posedge clk); #1;
    chk("to_berr_end", 32'(berr), 32'd0);
    chk("to_req_end", 32'(req), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
